// File: rtl/io_read_port_fifo_pkg.sv
// Shared header for the Scalar I/O port FIFOs (read-port and write-port).
// Holds the empty/full flag polarities and a constant clog2 helper
// for pointer widths.
package io_read_port_fifo_pkg;

  // Flag polarity seen by the Scalar: a high flag means "do not touch the port".
  localparam logic EF_EMPTY = 1'b1;
  localparam logic EF_FULL  = 1'b1;

  // Ceiling log2 for constant parameter expressions; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/io_read_port_fifo_storage.sv
// fifo_storage: WORD_WIDTH x DEPTH word array for the port FIFOs.
// Ports:
//   clock    in   write clock
//   wr_en    in   write mem[wr_addr] with wr_data at the clock edge
//   wr_addr  in   ADDR_WIDTH write address
//   wr_data  in   WORD_WIDTH write word
//   rd_addr  in   ADDR_WIDTH read address
//   rd_data  out  WORD_WIDTH word at rd_addr, read asynchronously
// Contents are never reset. RAMSTYLE is passed to synthesis as a ramstyle
// attribute; an empty string leaves the mapping to the tool.
module fifo_storage #(
  parameter int WORD_WIDTH = 36,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter     RAMSTYLE   = "logic"
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WORD_WIDTH-1:0] rd_data
);

  if (RAMSTYLE == "") begin : g_plain
    logic [WORD_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    assign rd_data = mem_q[rd_addr];
  end else begin : g_styled
    (* ramstyle = RAMSTYLE *) logic [WORD_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    assign rd_data = mem_q[rd_addr];
  end

endmodule

// File: rtl/io_read_port_fifo.sv
// io_read_port_fifo: first-word-fall-through FIFO feeding one Scalar I/O
// read port (io_in / io_in_EF / io_rden) from an external producer.
// Ports:
//   clock      in   clock for all state
//   reset_n    in   asynchronous active-low reset
//   in_valid   in   producer has a word on in_data
//   in_ready   out  FIFO accepts a word this cycle (level != DEPTH)
//   in_data    in   producer word
//   io_in_EF   out  1 = empty, 0 = io_in holds the head word
//   io_rden    in   Scalar pops the head word at this edge
//   io_in      out  head word, 0 when empty
//   level      out  occupancy 0..DEPTH
//   underflow  out  sticky: io_rden seen while empty
// All outputs decode registered state only, so nothing combinationally
// depends on in_valid or io_rden.
module io_read_port_fifo
  import io_read_port_fifo_pkg::*;
#(
  parameter int WORD_WIDTH = 36,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = clog2(DEPTH),
  parameter     RAMSTYLE   = "logic"
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_data,
  output logic                  io_in_EF,
  input  logic                  io_rden,
  output logic [WORD_WIDTH-1:0] io_in,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0]   FULL_LEVEL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   LVL_ONE    = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = (ADDR_WIDTH)'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic                  underflow_q, underflow_d;
  logic                  empty, full, push, pop;
  logic [WORD_WIDTH-1:0] head_word;

  // Full and empty come from the occupancy count; the pointers alone are
  // ambiguous when they are equal.
  assign empty = (level_q == '0);
  assign full  = (level_q == FULL_LEVEL);

  // A full FIFO refuses a push even when a pop frees a slot this same cycle;
  // in_ready rises the cycle after.
  assign push = in_valid & ~full;
  assign pop  = io_rden & ~empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    underflow_d = underflow_q | (io_rden & empty);
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_storage #(
    .WORD_WIDTH (WORD_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAMSTYLE   (RAMSTYLE)
  ) u_storage (
    .clock   (clock),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (in_data),
    .rd_addr (rd_ptr_q),
    .rd_data (head_word)
  );

  // Storage is not reset, so the head is masked to zero while empty.
  assign io_in     = empty ? '0 : head_word;
  assign io_in_EF  = empty ? EF_EMPTY : ~EF_EMPTY;
  assign in_ready  = ~full;
  assign level     = level_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_io_read_port_fifo.sv
module tb_io_read_port_fifo;

  localparam int W = 36;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          io_in_EF;
  logic          io_rden = 1'b0;
  logic [W-1:0]  io_in;
  logic [3:0]    level;
  logic          underflow;

  int n_vec = 0;
  int n_bad = 0;

  io_read_port_fifo #(
    .WORD_WIDTH (W),
    .DEPTH      (8),
    .ADDR_WIDTH (3),
    .RAMSTYLE   ("logic")
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .io_in_EF  (io_in_EF),
    .io_rden   (io_rden),
    .io_in     (io_in),
    .level     (level),
    .underflow (underflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic         vi;
    logic [W-1:0] din;
    logic         rden;
    logic         ef;
    logic         rdy;
    logic [3:0]   lvl;
    logic         uf;
    logic [W-1:0] io;
  } vec_t;

  vec_t tbl[$];

  // Small reference FIFO for the hand-written sequences.
  logic [W-1:0] mq[$];
  logic         m_uf;

  task automatic add(input logic vi, input logic [W-1:0] din, input logic rden,
                     input logic ef, input logic rdy, input logic [3:0] lvl,
                     input logic uf, input logic [W-1:0] io);
    vec_t v;
    v.vi = vi; v.din = din; v.rden = rden;
    v.ef = ef; v.rdy = rdy; v.lvl = lvl; v.uf = uf; v.io = io;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic e_ef, input logic e_rdy,
                       input logic [3:0] e_lvl, input logic e_uf, input logic [W-1:0] e_io);
    n_vec++;
    if ({io_in_EF, in_ready, level, underflow, io_in} !== {e_ef, e_rdy, e_lvl, e_uf, e_io}) begin
      n_bad++;
      $display("FAIL %s: got ef=%b rdy=%b lvl=%0d uf=%b io=%h, want ef=%b rdy=%b lvl=%0d uf=%b io=%h",
               name, io_in_EF, in_ready, level, underflow, io_in,
               e_ef, e_rdy, e_lvl, e_uf, e_io);
    end
  endtask

  // Drive at the falling edge, let one rising edge act, then sample 1 time unit later.
  task automatic drive(input logic vi, input logic [W-1:0] din, input logic rden);
    in_valid = vi;
    in_data  = din;
    io_rden  = rden;
    @(posedge clock);
    #1;
  endtask

  task automatic model_step(input string name, input logic vi, input logic [W-1:0] din,
                            input logic rden);
    bit m_full, m_empty;
    drive(vi, din, rden);
    m_full  = (mq.size() == 8);
    m_empty = (mq.size() == 0);
    if (rden && m_empty) m_uf = 1'b1;
    if (rden && !m_empty) void'(mq.pop_front());
    if (vi && !m_full) mq.push_back(din);
    check(name, mq.size() == 0, mq.size() != 8, 4'(mq.size()), m_uf,
          (mq.size() != 0) ? mq[0] : '0);
    @(negedge clock);
  endtask

  initial begin
    // Reset state
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    check("reset", 1'b1, 1'b1, 4'd0, 1'b0, '0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Idle, single push/pop
    add(0, 36'h0,  0, 1, 1, 0, 0, 36'h0);
    add(1, 36'hA5, 0, 0, 1, 1, 0, 36'hA5);
    add(0, 36'h0,  1, 1, 1, 0, 0, 36'h0);
    // Fill with 0..7, ninth push ignored, then drain in order
    for (int k = 0; k < 8; k++)
      add(1, W'(k), 0, 0, (k < 7), 4'(k + 1), 0, 36'h0);
    add(1, 36'hFF, 0, 0, 0, 8, 0, 36'h0);
    for (int j = 1; j <= 8; j++)
      add(0, 36'h0, 1, (j == 8), 1, 4'(8 - j), 0, (j < 8) ? W'(j) : 36'h0);
    // Fill again, then push+pop while full: pop only
    for (int k = 0; k < 8; k++)
      add(1, W'(32'h20 + k), 0, 0, (k < 7), 4'(k + 1), 0, 36'h20);
    add(1, 36'h99, 1, 0, 1, 7, 0, 36'h21);
    for (int j = 1; j <= 7; j++)
      add(0, 36'h0, 1, (j == 7), 1, 4'(7 - j), 0, (j < 7) ? W'(32'h21 + j) : 36'h0);
    // Pop while empty sets sticky underflow; push in the same cycle still lands
    add(0, 36'h0,  1, 1, 1, 0, 1, 36'h0);
    add(1, 36'h3C, 1, 0, 1, 1, 1, 36'h3C);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].vi, tbl[i].din, tbl[i].rden);
      check($sformatf("vec%0d", i), tbl[i].ef, tbl[i].rdy, tbl[i].lvl, tbl[i].uf, tbl[i].io);
      @(negedge clock);
    end

    // Reset mid-stream at level 5
    mq.delete();
    mq.push_back(36'h3C);
    m_uf = 1'b1;
    for (int k = 1; k <= 4; k++)
      model_step($sformatf("fill5_%0d", k), 1'b1, W'(32'h40 + k), 1'b0);
    reset_n = 1'b0;
    in_valid = 1'b0;
    io_rden  = 1'b0;
    #1;
    check("async_reset", 1'b1, 1'b1, 4'd0, 1'b0, '0);
    @(negedge clock);
    reset_n = 1'b1;
    mq.delete();
    m_uf = 1'b0;
    @(negedge clock);

    // Build level 3, then 20 cycles of simultaneous push and pop (wraps pointers)
    model_step("post_reset_push", 1'b1, 36'h55, 1'b0);
    model_step("lvl3_a", 1'b1, 36'h56, 1'b0);
    model_step("lvl3_b", 1'b1, 36'h57, 1'b0);
    for (int i = 0; i < 20; i++)
      model_step($sformatf("stream%0d", i), 1'b1, W'(32'h100 + i), 1'b1);
    for (int i = 0; i < 3; i++)
      model_step($sformatf("drain%0d", i), 1'b0, '0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
